// File: rtl/vai_mmio_initiator.sv
`default_nettype none
// ============================================================================
// Module   : vai_mmio_initiator
// Brief    : Single-outstanding CCI-P MMIO read/write initiator with tid-tagged
//            read completions, read timeout and stray-response counting.
// Revision : 1.0  initial release
// ============================================================================
module vai_mmio_initiator #(
  parameter int TIMEOUT_CYCLES = 512,
  parameter int TID_WIDTH      = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_is_write,
  input  logic [15:0]          cmd_addr,
  input  logic [63:0]          cmd_data,
  output logic                 mmio_rd_valid,
  output logic                 mmio_wr_valid,
  output logic [15:0]          mmio_addr,
  output logic [1:0]           mmio_length,
  output logic [TID_WIDTH-1:0] mmio_tid,
  output logic [63:0]          mmio_data,
  input  logic                 c2_rd_valid,
  input  logic [TID_WIDTH-1:0] c2_tid,
  input  logic [63:0]          c2_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_is_write,
  output logic                 rsp_error,
  output logic [63:0]          rsp_data,
  output logic [15:0]          stray_cnt
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  // WAIT lasts TIMEOUT_CYCLES-1 cycles so rsp_valid lands TIMEOUT_CYCLES after ISSUE.
  localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [TID_WIDTH-1:0] r_tid_ctr;
  logic [TID_WIDTH-1:0] r_issued_tid;
  logic [CNT_W-1:0]     r_to_cnt;
  logic [15:0]          r_addr;
  logic [63:0]          r_data;
  logic                 r_is_write;
  logic                 r_rsp_is_write;
  logic                 r_rsp_error;
  logic [63:0]          r_rsp_data;
  logic [15:0]          r_stray_cnt;

  logic w_match;
  logic w_expired;
  logic w_stray;

  assign w_match   = c2_rd_valid && (r_state == c_ST_WAIT) && (c2_tid == r_issued_tid);
  assign w_expired = (r_state == c_ST_WAIT) && !w_match && (r_to_cnt == c_TO_LAST);
  assign w_stray   = c2_rd_valid && !w_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (cmd_valid) begin
          w_next_state = cmd_addr[0] ? c_ST_DONE : c_ST_ISSUE;
        end
      end
      c_ST_ISSUE: w_next_state = r_is_write ? c_ST_DONE : c_ST_WAIT;
      c_ST_WAIT: begin
        if (w_match || w_expired) begin
          w_next_state = c_ST_DONE;
        end
      end
      default: begin
        if (rsp_ready) begin
          w_next_state = c_ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tid_ctr      <= '0;
      r_issued_tid   <= '0;
      r_to_cnt       <= '0;
      r_addr         <= '0;
      r_data         <= '0;
      r_is_write     <= 1'b0;
      r_rsp_is_write <= 1'b0;
      r_rsp_error    <= 1'b0;
      r_rsp_data     <= '0;
      r_stray_cnt    <= '0;
    end else begin
      if (w_stray && (r_stray_cnt != 16'hFFFF)) begin
        r_stray_cnt <= r_stray_cnt + 16'd1;
      end
      case (r_state)
        c_ST_IDLE: begin
          if (cmd_valid) begin
            r_addr         <= cmd_addr;
            r_data         <= cmd_data;
            r_is_write     <= cmd_is_write;
            r_rsp_is_write <= cmd_is_write;
            r_rsp_error    <= cmd_addr[0];
            r_rsp_data     <= cmd_addr[0] ? '1 : '0;
          end
        end
        c_ST_ISSUE: begin
          r_to_cnt <= '0;
          if (!r_is_write) begin
            r_issued_tid <= r_tid_ctr;
            r_tid_ctr    <= r_tid_ctr + TID_WIDTH'(1);
          end
        end
        c_ST_WAIT: begin
          if (w_match) begin
            r_rsp_error <= 1'b0;
            r_rsp_data  <= c2_data;
          end else if (w_expired) begin
            r_rsp_error <= 1'b1;
            r_rsp_data  <= '1;
          end else begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_ready     = (r_state == c_ST_IDLE);
    mmio_rd_valid = 1'b0;
    mmio_wr_valid = 1'b0;
    mmio_addr     = '0;
    mmio_length   = 2'b01;
    mmio_tid      = '0;
    mmio_data     = '0;
    rsp_valid     = 1'b0;
    rsp_is_write  = 1'b0;
    rsp_error     = 1'b0;
    rsp_data      = '0;
    stray_cnt     = r_stray_cnt;
    if (r_state == c_ST_ISSUE) begin
      mmio_rd_valid = !r_is_write;
      mmio_wr_valid = r_is_write;
      mmio_addr     = r_addr;
      mmio_tid      = r_tid_ctr;
      mmio_data     = r_is_write ? r_data : '0;
    end
    if (r_state == c_ST_DONE) begin
      rsp_valid    = 1'b1;
      rsp_is_write = r_rsp_is_write;
      rsp_error    = r_rsp_error;
      rsp_data     = r_rsp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vai_mmio_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_vai_mmio_initiator
// Brief    : Table-driven and randomized bench for vai_mmio_initiator.
// Revision : 1.0  initial release
// ============================================================================
module tb_vai_mmio_initiator;

  localparam int T  = 16;
  localparam int TW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_is_write;
  logic [15:0]   cmd_addr;
  logic [63:0]   cmd_data;
  logic          mmio_rd_valid, mmio_wr_valid;
  logic [15:0]   mmio_addr;
  logic [1:0]    mmio_length;
  logic [TW-1:0] mmio_tid;
  logic [63:0]   mmio_data;
  logic          c2_rd_valid;
  logic [TW-1:0] c2_tid;
  logic [63:0]   c2_data;
  logic          rsp_valid, rsp_ready, rsp_is_write, rsp_error;
  logic [63:0]   rsp_data;
  logic [15:0]   stray_cnt;

  always #5 clk = ~clk;

  vai_mmio_initiator #(.TIMEOUT_CYCLES(T), .TID_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_write(cmd_is_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
    .mmio_addr(mmio_addr), .mmio_length(mmio_length), .mmio_tid(mmio_tid),
    .mmio_data(mmio_data),
    .c2_rd_valid(c2_rd_valid), .c2_tid(c2_tid), .c2_data(c2_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_write(rsp_is_write),
    .rsp_error(rsp_error), .rsp_data(rsp_data), .stray_cnt(stray_cnt)
  );

  typedef struct {
    bit          w;
    logic [15:0] addr;
    logic [63:0] data;     // write data, or data the responder returns
    int          delay;    // WAIT cycle (1-based) in which the responder answers
    bit          respond;
    bit          bad;      // mismatched tid one cycle before the real response
    bit          late;     // response injected after completion
    int          hold;     // cycles rsp_ready stays low
    bit          exp_err;
    int          exp_lat;  // cycles from acceptance edge to rsp_valid
  } vec_t;

  int checks = 0;
  int errors = 0;
  int model_tid = 0;
  int model_stray = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_strobes", 64'({mmio_rd_valid, mmio_wr_valid}), 64'd0);
    check("rst_mmio_addr", 64'(mmio_addr), 64'd0);
    check("rst_mmio_length", 64'(mmio_length), 64'd1);
    check("rst_mmio_tid", 64'(mmio_tid), 64'd0);
    check("rst_mmio_data", mmio_data, 64'd0);
    check("rst_rsp_flags", 64'({rsp_valid, rsp_is_write, rsp_error}), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_stray_cnt", 64'(stray_cnt), 64'd0);
  endtask

  task automatic do_txn(input vec_t v);
    logic [63:0]   exp_rdata;
    logic [TW-1:0] tid;
    int            lat;
    int            strobes;
    bit            aligned;
    aligned   = !v.addr[0];
    tid       = TW'(model_tid);
    exp_rdata = v.exp_err ? 64'hFFFF_FFFF_FFFF_FFFF : (v.w ? 64'd0 : v.data);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_is_write = v.w; cmd_addr = v.addr; cmd_data = v.data;
    tick;
    cmd_valid = 1'b0; cmd_data = {$urandom, $urandom}; cmd_addr = 16'($urandom);
    lat = 1;
    strobes = 0;
    while (!rsp_valid && lat < T + 6) begin
      if (mmio_rd_valid || mmio_wr_valid) begin
        strobes++;
        check("req_kind", 64'({mmio_wr_valid, mmio_rd_valid}), v.w ? 64'd2 : 64'd1);
        check("req_addr", 64'(mmio_addr), 64'(v.addr));
        check("req_length", 64'(mmio_length), 64'd1);
        check("req_tid", 64'(mmio_tid), 64'(tid));
        check("req_data", mmio_data, v.w ? v.data : 64'd0);
      end
      if (v.respond && (lat - 1 == v.delay)) begin
        c2_rd_valid = 1'b1; c2_tid = tid; c2_data = v.data;
      end else if (v.bad && (lat - 1 == v.delay - 1)) begin
        c2_rd_valid = 1'b1; c2_tid = tid ^ TW'(1); c2_data = ~v.data;
      end else begin
        c2_rd_valid = 1'b0; c2_data = {$urandom, $urandom};
      end
      tick;
      lat++;
    end
    c2_rd_valid = 1'b0;
    if (aligned && !v.w) model_tid = (model_tid + 1) % (1 << TW);
    if (v.bad) model_stray++;
    check("latency", 64'(lat), 64'(v.exp_lat));
    check("strobe_count", 64'(strobes), aligned ? 64'd1 : 64'd0);
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("rsp_is_write", 64'(rsp_is_write), 64'(v.w));
    check("rsp_error", 64'(rsp_error), 64'(v.exp_err));
    check("rsp_data", rsp_data, exp_rdata);
    for (int h = 0; h < v.hold; h++) begin
      tick;
      check("hold_flags", 64'({rsp_valid, rsp_is_write, rsp_error, cmd_ready}),
            64'({1'b1, v.w, v.exp_err, 1'b0}));
      check("hold_data", rsp_data, exp_rdata);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("rsp_valid_clear", 64'(rsp_valid), 64'd0);
    check("cmd_ready_back", 64'(cmd_ready), 64'd1);
    if (v.late) begin
      c2_rd_valid = 1'b1; c2_tid = tid; c2_data = v.data;
      tick;
      c2_rd_valid = 1'b0;
      model_stray++;
    end
    check("stray_cnt", 64'(stray_cnt), 64'(model_stray));
  endtask

  // Expected completion timing and error flag derived from the protocol rules.
  function automatic vec_t make_vec(input int kind);
    vec_t v;
    v.data    = {$urandom, $urandom};
    v.addr    = 16'($urandom) & 16'hFFFE;
    v.w       = 1'b0;
    v.delay   = 0;
    v.respond = 1'b0;
    v.bad     = 1'b0;
    v.late    = 1'b0;
    v.hold    = int'($urandom_range(0, 3));
    v.exp_err = 1'b0;
    if (kind <= 2) begin
      v.w = 1'b1;
      v.exp_lat = 2;
    end else if (kind == 3) begin
      v.w = 1'($urandom_range(0, 1));
      v.addr = v.addr | 16'h0001;
      v.exp_err = 1'b1;
      v.exp_lat = 1;
    end else if (kind <= 8) begin
      v.delay = int'($urandom_range(1, T - 1));
      v.respond = 1'b1;
      v.bad = (v.delay >= 2) && ($urandom_range(0, 1) == 1);
      v.exp_lat = v.delay + 2;
    end else begin
      v.late = 1'($urandom_range(0, 1));
      v.exp_err = 1'b1;
      v.exp_lat = T + 1;
    end
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] old_tid;
    vec_t v;
    reset = 1'b1; cmd_valid = 1'b0; cmd_is_write = 1'b0; cmd_addr = '0; cmd_data = '0;
    c2_rd_valid = 1'b0; c2_tid = '0; c2_data = '0; rsp_ready = 1'b0;
    repeat (3) tick;
    reset = 1'b0;
    check_reset_outputs;

    vecs[0] = '{1'b1, 16'h000C, 64'h1234, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2};
    vecs[1] = '{1'b0, 16'h0002, 64'hD1D383AACA4C4C60, 5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 7};
    vecs[2] = '{1'b0, 16'h0004, 64'h5555, 0, 1'b0, 1'b0, 1'b1, 0, 1'b1, T + 1};
    vecs[3] = '{1'b0, 16'h0006, 64'hCAFE_F00D_0BAD_BEEF, 4, 1'b1, 1'b1, 1'b0, 10, 1'b0, 6};
    vecs[4] = '{1'b0, 16'h0003, 64'h0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1};
    vecs[5] = '{1'b1, 16'h0005, 64'h77, 0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1};
    vecs[6] = '{1'b0, 16'h0008, 64'h0123_4567_89AB_CDEF, T - 1, 1'b1, 1'b0, 1'b0, 0, 1'b0, T + 1};
    vecs[7] = '{1'b0, 16'h000A, 64'hA5A5, 1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 3};
    for (int i = 0; i < 8; i++) do_txn(vecs[i]);

    // Reset while a read is outstanding; its late response must count as stray.
    cmd_valid = 1'b1; cmd_is_write = 1'b0; cmd_addr = 16'h0010; cmd_data = '0;
    tick;
    cmd_valid = 1'b0;
    old_tid = TW'(model_tid);
    check("rstwait_issue", 64'({mmio_rd_valid, mmio_tid}), 64'({1'b1, old_tid}));
    tick; tick;
    check("rstwait_pending", 64'({rsp_valid, cmd_ready}), 64'd0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_reset_outputs;
    model_tid = 0;
    model_stray = 0;
    c2_rd_valid = 1'b1; c2_tid = old_tid; c2_data = 64'h1;
    tick;
    c2_rd_valid = 1'b0;
    model_stray++;
    check("rstwait_stray", 64'(stray_cnt), 64'(model_stray));
    v = '{1'b0, 16'h0010, 64'h600D, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0, 5};
    do_txn(v);

    // 513 reads: tid walks through 511 and wraps to 0.
    for (int i = 0; i < 513; i++) begin
      v = make_vec(4);
      v.bad = 1'b0;
      v.delay = int'($urandom_range(1, 3));
      v.exp_lat = v.delay + 2;
      v.hold = 0;
      do_txn(v);
    end

    for (int i = 0; i < 150; i++) begin
      v = make_vec(int'($urandom_range(0, 9)));
      do_txn(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
